ifetch_queue: RTL and testbench

- Parametrised instruction-fetch front end placed between the Sirius core and the instruction ROM. It replaces the direct core-to-ROM address/data wiring.
- Autonomously issues sequential fetch addresses to a fixed-latency instruction memory. Buffers returned words with their PCs in a DEPTH-entry FIFO.
- Presents instructions to the core through a valid/ready handshake.
- Supports a redirect (branch/jump) that flushes buffered and in-flight fetches.

---
 rtl/ifetch_queue.sv | 128 ++++++++++++
 tb/tb_ifetch_queue.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - sequential instruction prefetch queue with redirect flush
module ifetch_queue #(
   parameter int                ADDR_W      = 32,
   parameter int                DATA_W      = 32,
   parameter int                DEPTH       = 4,
   parameter int                MEM_LATENCY = 1,
   parameter logic [ADDR_W-1:0] RESET_PC    = '0,
   parameter int                PC_STEP     = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      redirect_i,
   input  logic [ADDR_W-1:0]         redirect_pc_i,
   output logic                      mem_ce_o,
   output logic [ADDR_W-1:0]         mem_addr_o,
   input  logic [DATA_W-1:0]         mem_data_i,
   output logic                      inst_valid_o,
   output logic [DATA_W-1:0]         inst_o,
   output logic [ADDR_W-1:0]         inst_pc_o,
   input  logic                      inst_ready_i,
   output logic [$clog2(DEPTH):0]    count_o
);

   localparam int                PTR_W   = $clog2(DEPTH);
   localparam int                CNT_W   = PTR_W + 1;
   localparam logic [ADDR_W-1:0] PC_INC  = ADDR_W'(PC_STEP);
   localparam logic [ADDR_W-1:0] PC_MASK = ~(ADDR_W'(PC_STEP - 1));

   logic [ADDR_W-1:0]      fetch_pc;
   logic [MEM_LATENCY-1:0] pipe_vld;
   logic [ADDR_W-1:0]      pipe_pc [MEM_LATENCY];
   logic [DATA_W-1:0]      fifo_data [DEPTH];
   logic [ADDR_W-1:0]      fifo_pc [DEPTH];
   logic [PTR_W-1:0]       rd_ptr;
   logic [PTR_W-1:0]       wr_ptr;
   logic [CNT_W-1:0]       count;
   int                     inflight;
   logic                   push;
   logic                   pop;

   // Count requests still travelling through the memory pipe.
   always_comb begin
      inflight = 0;
      for (int i = 0; i < MEM_LATENCY; i++) begin
         inflight = inflight + int'(pipe_vld[i]);
      end
   end

   // Issue only when every outstanding request is guaranteed a FIFO slot.
   assign mem_ce_o   = !rst && !redirect_i && ((int'(count) + inflight) < DEPTH);
   assign mem_addr_o = fetch_pc;

   // A redirect discards the response arriving this edge and any pop.
   assign push = pipe_vld[MEM_LATENCY-1] && !redirect_i;
   assign pop  = inst_valid_o && inst_ready_i && !redirect_i;

   // Fetch address: restart on reset/redirect, advance on every issue.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc <= RESET_PC;
      end else if (redirect_i) begin
         fetch_pc <= redirect_pc_i & PC_MASK;
      end else if (mem_ce_o) begin
         fetch_pc <= fetch_pc + PC_INC;
      end
   end

   // Valid tags of in-flight requests; a redirect kills all of them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pipe_vld <= '0;
      end else if (redirect_i) begin
         pipe_vld <= '0;
      end else begin
         pipe_vld[0] <= mem_ce_o;
         for (int i = 1; i < MEM_LATENCY; i++) begin
            pipe_vld[i] <= pipe_vld[i-1];
         end
      end
   end

   // Addresses of in-flight requests travel alongside their tags.
   always_ff @(posedge clk) begin
      pipe_pc[0] <= mem_addr_o;
      for (int i = 1; i < MEM_LATENCY; i++) begin
         pipe_pc[i] <= pipe_pc[i-1];
      end
   end

   // FIFO storage: returned word paired with the pc that requested it.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_data[wr_ptr] <= mem_data_i;
         fifo_pc[wr_ptr]   <= pipe_pc[MEM_LATENCY-1];
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (redirect_i) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (push && !pop)      count <= count + CNT_W'(1);
         else if (pop && !push) count <= count - CNT_W'(1);
      end
   end

   // The issue throttle must make a write into a full FIFO impossible.
   always_ff @(posedge clk) begin
      if (!rst && push && !pop) begin
         assert (int'(count) < DEPTH);
      end
   end

   assign inst_valid_o = (count != '0);
   assign inst_o       = inst_valid_o ? fifo_data[rd_ptr] : '0;
   assign inst_pc_o    = inst_valid_o ? fifo_pc[rd_ptr]   : '0;
   assign count_o      = count;

endmodule

// File: tb/tb_ifetch_queue.sv
// tb/tb_ifetch_queue.sv - randomized and directed check of ifetch_queue against a queue model
module tb_ifetch_queue;

   typedef logic [31:0] q32_t[$];
   typedef int          qi_t[$];

   logic        clk;
   logic        rst;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        ready;

   logic        ce0, ce1, v0, v1;
   logic [31:0] addr0, addr1, data0, data1, inst0, inst1, pc0, pc1;
   logic [2:0]  cnt0, cnt1;

   int n_cmp = 0;
   int n_err = 0;

   q32_t        fq0, pq0, fq1, pq1;
   qi_t         r0, r1;
   logic [31:0] fpc0, fpc1;
   logic [31:0] h0 [3];
   logic [31:0] h1 [3];

   ifetch_queue #(.DEPTH(4), .MEM_LATENCY(1), .RESET_PC(32'h0)) u0 (
      .clk(clk), .rst(rst), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
      .mem_ce_o(ce0), .mem_addr_o(addr0), .mem_data_i(data0),
      .inst_valid_o(v0), .inst_o(inst0), .inst_pc_o(pc0),
      .inst_ready_i(ready), .count_o(cnt0));

   ifetch_queue #(.DEPTH(4), .MEM_LATENCY(3), .RESET_PC(32'h80)) u1 (
      .clk(clk), .rst(rst), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
      .mem_ce_o(ce1), .mem_addr_o(addr1), .mem_data_i(data1),
      .inst_valid_o(v1), .inst_o(inst1), .inst_pc_o(pc1),
      .inst_ready_i(ready), .count_o(cnt1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] rom(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic mreset();
      fq0.delete(); pq0.delete(); r0.delete(); fpc0 = 32'h0;
      fq1.delete(); pq1.delete(); r1.delete(); fpc1 = 32'h80;
   endtask

   task automatic medge(input int ml, inout logic [31:0] fpc, inout q32_t fq,
                        inout q32_t pq, inout qi_t rem);
      bit issue, take;
      if (rst) return;
      issue = !redirect && ((fq.size() + pq.size()) < 4);
      take  = (fq.size() != 0) && ready;
      if (redirect) begin
         fq.delete(); pq.delete(); rem.delete();
         fpc = redirect_pc & 32'hFFFF_FFFC;
      end else begin
         if (take) void'(fq.pop_front());
         foreach (rem[i]) rem[i] = rem[i] - 1;
         if (rem.size() != 0 && rem[0] == 0) begin
            fq.push_back(pq.pop_front());
            void'(rem.pop_front());
         end
         if (issue) begin
            pq.push_back(fpc);
            rem.push_back(ml);
            fpc = fpc + 32'd4;
         end
      end
   endtask

   task automatic chk_inst(input string nm, input logic [31:0] fpc, input q32_t fq, input int infl,
                           input logic ce, input logic [31:0] addr, input logic v,
                           input logic [31:0] inst, input logic [31:0] pc, input logic [2:0] cnt);
      logic e_ce;
      e_ce = !rst && !redirect && ((fq.size() + infl) < 4);
      chk({nm, ".ce"}, 32'(ce), 32'(e_ce));
      chk({nm, ".addr"}, addr, fpc);
      chk({nm, ".valid"}, 32'(v), 32'(fq.size() != 0));
      chk({nm, ".count"}, 32'(cnt), 32'(fq.size()));
      if (fq.size() != 0) begin
         chk({nm, ".pc"}, pc, fq[0]);
         chk({nm, ".inst"}, inst, rom(fq[0]));
      end
   endtask

   task automatic chk_all();
      chk_inst("m1", fpc0, fq0, pq0.size(), ce0, addr0, v0, inst0, pc0, cnt0);
      chk_inst("m3", fpc1, fq1, pq1.size(), ce1, addr1, v1, inst1, pc1, cnt1);
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, ".ce0"}, 32'(ce0), 32'd0);
      chk({nm, ".v0"}, 32'(v0), 32'd0);
      chk({nm, ".inst0"}, inst0, 32'd0);
      chk({nm, ".pc0"}, pc0, 32'd0);
      chk({nm, ".cnt0"}, 32'(cnt0), 32'd0);
      chk({nm, ".ce1"}, 32'(ce1), 32'd0);
      chk({nm, ".v1"}, 32'(v1), 32'd0);
      chk({nm, ".inst1"}, inst1, 32'd0);
      chk({nm, ".pc1"}, pc1, 32'd0);
      chk({nm, ".cnt1"}, 32'(cnt1), 32'd0);
   endtask

   // One clock: model update at the edge, memory data shortly after, checks at the falling edge.
   task automatic step();
      logic [31:0] a0, a1;
      a0 = addr0;
      a1 = addr1;
      @(posedge clk);
      medge(1, fpc0, fq0, pq0, r0);
      medge(3, fpc1, fq1, pq1, r1);
      #1;
      h0[2] = h0[1]; h0[1] = h0[0]; h0[0] = a0;
      h1[2] = h1[1]; h1[1] = h1[0]; h1[0] = a1;
      data0 = rom(h0[0]);
      data1 = rom(h1[2]);
      @(negedge clk);
      chk_all();
   endtask

   task automatic reset_cycle(input logic rdy);
      @(negedge clk);
      rst = 1'b1;
      ready = rdy;
      mreset();
      step();
      rst = 1'b0;
      #1;
   endtask

   initial begin
      int waited;
      rst = 1'b1; redirect = 1'b0; redirect_pc = '0; ready = 1'b0;
      data0 = '0; data1 = '0;
      for (int i = 0; i < 3; i++) begin h0[i] = '0; h1[i] = '0; end
      mreset();
      repeat (2) @(negedge clk);
      chk_zero("reset");

      // Reset release with ready high: sequential issue, first data two cycles later.
      ready = 1'b1;
      rst = 1'b0;
      #1;
      chk("rel.ce0", 32'(ce0), 32'd1);
      chk("rel.addr0", addr0, 32'h0);
      chk("rel.addr1", addr1, 32'h80);
      for (int k = 1; k <= 10; k++) begin
         step();
         chk("seq.addr0", addr0, 32'(k * 4));
         if (k == 1) chk("seq.nvalid", 32'(v0), 32'd0);
         if (k >= 2) begin
            chk("tp.valid", 32'(v0), 32'd1);
            chk("tp.pc", pc0, 32'((k - 2) * 4));
         end
      end

      // Ready low from reset: four issues then stall, single pop frees one slot.
      reset_cycle(1'b0);
      repeat (8) step();
      chk("stall.cnt0", 32'(cnt0), 32'd4);
      chk("stall.ce0", 32'(ce0), 32'd0);
      chk("stall.pc0", pc0, 32'h0);
      chk("stall.addr0", addr0, 32'h10);
      chk("stall.cnt1", 32'(cnt1), 32'd4);
      chk("stall.pc1", pc1, 32'h80);
      ready = 1'b1;
      step();
      ready = 1'b0;
      #1;
      chk("resume.cnt0", 32'(cnt0), 32'd3);
      chk("resume.ce0", 32'(ce0), 32'd1);
      chk("resume.addr0", addr0, 32'h10);
      step();
      chk("refill.ce0", 32'(ce0), 32'd0);

      // Redirect with two queued entries and one fetch in flight.
      reset_cycle(1'b0);
      repeat (3) step();
      chk("pre.cnt0", 32'(cnt0), 32'd2);
      redirect = 1'b1;
      redirect_pc = 32'h103;
      #1;
      chk("redir.ce0", 32'(ce0), 32'd0);
      step();
      chk("redir.cnt0", 32'(cnt0), 32'd0);
      chk("redir.v0", 32'(v0), 32'd0);
      redirect = 1'b0;
      ready = 1'b1;
      #1;
      chk("redir.ce_next", 32'(ce0), 32'd1);
      chk("redir.addr0", addr0, 32'h100);
      waited = 0;
      while (!v0 && waited < 10) begin
         step();
         waited++;
      end
      chk("redir.seen", 32'(v0), 32'd1);
      chk("redir.first_pc", pc0, 32'h100);

      // Address wrap at the top of the address space.
      @(negedge clk);
      redirect = 1'b1;
      redirect_pc = 32'hFFFF_FFFE;
      step();
      redirect = 1'b0;
      #1;
      chk("wrap.addr_a", addr0, 32'hFFFF_FFFC);
      step();
      chk("wrap.addr_b", addr0, 32'h0);
      step();
      chk("wrap.pc_a", pc0, 32'hFFFF_FFFC);
      step();
      chk("wrap.pc_b", pc0, 32'h0);

      // Back-to-back redirects: the last one wins.
      redirect = 1'b1;
      redirect_pc = 32'h400;
      step();
      redirect_pc = 32'h804;
      step();
      chk("b2b.ce0", 32'(ce0), 32'd0);
      redirect = 1'b0;
      #1;
      chk("b2b.addr0", addr0, 32'h804);
      repeat (4) step();

      // Randomized traffic, every cycle checked against the model.
      for (int k = 0; k < 600; k++) begin
         ready = ($urandom_range(0, 3) != 0);
         redirect = ($urandom_range(0, 24) == 0);
         redirect_pc = $urandom;
         if (k >= 300 && k < 360) ready = 1'b1;
         if (k >= 400 && k < 440) ready = 1'b0;
         step();
      end
      redirect = 1'b0;
      ready = 1'b1;
      repeat (4) step();

      // Asynchronous reset between edges clears outputs at once.
      #2;
      rst = 1'b1;
      mreset();
      #1;
      chk_zero("async");
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("arst.addr1", addr1, 32'h80);
      chk("arst.ce1", 32'(ce1), 32'd1);
      chk("arst.addr0", addr0, 32'h0);
      repeat (12) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
